csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Machine-mode CSR unit for the single-hart core, driven by the controller. Replaces a flat 4096-entry array with only the implemented CSRs.
- Performs CSRRW/CSRRS/CSRRC read-modify-write and detects illegal accesses.
- Runs 64-bit mcycle/minstret counters.
- Sequences trap entry and mret, and raises the machine timer interrupt request.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- HARTID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- MISA_VALUE, 32'h4000_0100, value returned by misa (RV32I).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- csr_valid  in  1  CSR instruction this cycle.
- csr_op  in  2  01=RW, 10=RS, 11=RC; 00 is treated as no access.
- csr_addr  in  12  CSR address.
- csr_src_zero  in  1  rs1/uimm field is zero, so RS/RC does not write.
- csr_wdata  in  32  source operand.
- csr_rdata  out  32  old CSR value, combinational.
- csr_illegal  out  1  access is illegal, combinational.
- instret  in  1  one instruction retired this cycle.
- timer_irq  in  1  level-sensitive timer interrupt, mirrored into mip.MTIP.
- trap_valid  in  1  take a trap this cycle.
- trap_cause  in  32  mcause value; bit31 set for an interrupt.
- trap_pc  in  32  PC to save in mepc.
- trap_tval  in  32  value for mtval.
- mret_valid  in  1  mret this cycle.
- redirect_valid  out  1  PC redirect, combinational.
- redirect_pc  out  32  redirect target.
- irq_pending  out  1  mstatus.MIE & mie.MTIE & mip.MTIP.
- mtvec  out  32  current mtvec.
- mepc  out  32  current mepc.

Behaviour:
- Implemented CSRs, with all other bits reading 0:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11.
  - misa 0x301, read-only in effect: writes are ignored.
  - mie 0x304: MTIE bit7.
  - mtvec 0x305: BASE[31:2], MODE[1:0]; MODE values 2 and 3 are written as 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] always 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: MTIP bit7, read-only.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - mhartid 0xF14.
- Read: csr_rdata is the pre-write value of csr_addr, combinational. It is 0 when csr_valid=0 or the address is unimplemented.
- Write intent: RW always; RS/RC only when csr_src_zero=0.
- New value: RW = wdata; RS = old | wdata; RC = old & ~wdata. It is written at the next posedge.
- csr_illegal=1 when csr_valid and csr_op!=00 and either:
  - the address is unimplemented; or
  - there is write intent and csr_addr[11:10]==2'b11.
- An illegal access writes nothing. The controller converts it to a trap on a later cycle.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instret=1.
  - Both are 64-bit and wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - A CSR write to either half in the same cycle wins over the increment; the other half holds.
  - Carry from the low half to the high half lands in the same cycle.
- Trap entry (trap_valid=1), at the next posedge:
  - mepc <= {trap_pc[31:2], 2'b00}; mcause <= trap_cause; mtval <= trap_tval.
  - MPIE <= MIE; MIE <= 0.
  - redirect_valid=1 in the same cycle.
  - redirect_pc = {mtvec[31:2], 2'b00}. If MODE=1 and trap_cause[31]=1, add 4*trap_cause[4:0].
- mret (mret_valid=1), at the next posedge:
  - MIE <= MPIE; MPIE <= 1.
  - redirect_valid=1, redirect_pc = mepc.
- Priority: trap_valid > mret_valid > CSR write.
  - A CSR write in a trap or mret cycle is dropped.
  - csr_rdata is still driven in those cycles.
- irq_pending uses registered state; a write to mie or mstatus affects it from the next cycle.
- Reset:
  - All CSRs are 0, except mtvec=MTVEC_RESET and MPP=2'b11.
  - Counters are 0.
  - redirect_valid=0 and irq_pending=0 while rst is high. Reset overrides all events in the same cycle.

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants and field bit positions;
  - csr_op encodings;
  - cause codes for MTI (0x8000_0007), illegal instruction (2) and ecall (11).
- One natural sub-module: csr_counter64, a 64-bit counter with an increment enable and separate lo/hi write ports where a write wins over the increment. It is instantiated twice.

Test Plan:
- After reset: read 0x305 -> MTVEC_RESET; read 0x300 -> 0x0000_1800; read 0xF14 -> HARTID. csr_illegal=0 on all three.
- CSRRW mscratch=0xDEAD_BEEF, then CSRRS with 0x0000_0010 -> rdata 0xDEAD_BEEF, next read 0xDEAD_BEFF. Then CSRRC with 0x0000_00FF -> 0xDEAD_BE00.
- Write to 0xF14 -> csr_illegal=1, no state change. CSRRS to 0xF14 with csr_src_zero=1 -> legal read. Access to 0x7C0 -> illegal, rdata 0.
- Write mcycle=0xFFFF_FFFE and mcycleh=0xFFFF_FFFF, then idle 3 cycles -> {mcycleh, mcycle} = 0x0000_0000_0000_0001 (wrapped). A write in the increment cycle -> the written value holds.
- MIE=1, MTIE=1, timer_irq=1 -> irq_pending=1. trap_valid with cause 0x8000_0007, pc 0x100, vectored mtvec 0x201 -> redirect_pc 0x21C, mepc 0x100, MIE=0, MPIE=1. Then mret -> redirect_pc 0x100, MIE=1.
- trap_valid, mret_valid and a CSRRW to mscratch in the same cycle -> only the trap takes effect; mscratch is unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, field positions,
// operation encodings and trap cause codes.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIP_MTIP     = 7;
    localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    // MODE values 2 and 3 are reserved and collapse to direct mode.
    function automatic logic [31:0] mtvec_legalize(input logic [31:0] v);
        return {v[31:2], (v[1] ? 2'b00 : v[1:0])};
    endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the controller (master) and the CSR unit (slave).
// Single-cycle request: rdata/illegal answer combinationally in the csr_valid cycle.
interface csr_if;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic        csr_src_zero;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_valid, csr_op, csr_addr, csr_src_zero, csr_wdata,
        input  csr_rdata, csr_illegal
    );
    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_src_zero, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half write ports; a write to one half
// takes precedence over the increment and leaves the other half unchanged.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);
    logic [63:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 64'd0;
        end else if (i_wr_lo) begin
            r_count[31:0] <= i_wdata;
        end else if (i_wr_hi) begin
            r_count[63:32] <= i_wdata;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: implemented CSRs only, read-modify-write access,
// 64-bit cycle/instret counters, trap entry / mret sequencing and timer IRQ.
module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          HARTID      = 0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            rst,
    csr_if.slave            csr,
    input  logic            instret,
    input  logic            timer_irq,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            irq_pending,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc
);
    logic        r_mie, r_mpie, r_mtie, r_mtip;
    logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;

    logic [63:0] w_mcycle, w_minstret;
    logic [31:0] w_old, w_new;
    logic        w_impl, w_access, w_wr_intent, w_illegal, w_we;

    always_comb begin
        w_old  = 32'd0;
        w_impl = 1'b1;
        case (csr.csr_addr)
            CSR_MSTATUS: begin
                w_old[12:11]        = MSTATUS_MPP_M;
                w_old[MSTATUS_MPIE] = r_mpie;
                w_old[MSTATUS_MIE]  = r_mie;
            end
            CSR_MISA:      w_old = MISA_VALUE;
            CSR_MIE:       w_old[MIE_MTIE] = r_mtie;
            CSR_MTVEC:     w_old = r_mtvec;
            CSR_MSCRATCH:  w_old = r_mscratch;
            CSR_MEPC:      w_old = r_mepc;
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MTVAL:     w_old = r_mtval;
            CSR_MIP:       w_old[MIP_MTIP] = r_mtip;
            CSR_MCYCLE:    w_old = w_mcycle[31:0];
            CSR_MCYCLEH:   w_old = w_mcycle[63:32];
            CSR_MINSTRET:  w_old = w_minstret[31:0];
            CSR_MINSTRETH: w_old = w_minstret[63:32];
            CSR_MHARTID:   w_old = 32'(HARTID);
            default:       w_impl = 1'b0;
        endcase
    end

    always_comb begin
        w_new = csr.csr_wdata;
        case (csr_op_e'(csr.csr_op))
            CSR_OP_RS: w_new = w_old | csr.csr_wdata;
            CSR_OP_RC: w_new = w_old & ~csr.csr_wdata;
            default:   w_new = csr.csr_wdata;
        endcase
    end

    assign w_access    = csr.csr_valid && (csr.csr_op != CSR_OP_NONE);
    assign w_wr_intent = (csr.csr_op == CSR_OP_RW) || !csr.csr_src_zero;
    // Addresses with [11:10]==2'b11 are the read-only CSR space.
    assign w_illegal   = w_access && (!w_impl || (w_wr_intent && (csr.csr_addr[11:10] == 2'b11)));
    assign w_we        = w_access && w_wr_intent && !w_illegal && !trap_valid && !mret_valid;

    assign csr.csr_rdata   = csr.csr_valid ? w_old : 32'd0;
    assign csr.csr_illegal = w_illegal;

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_we && (csr.csr_addr == CSR_MCYCLE)),
        .i_wr_hi (w_we && (csr.csr_addr == CSR_MCYCLEH)),
        .i_wdata (w_new),
        .o_count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (instret),
        .i_wr_lo (w_we && (csr.csr_addr == CSR_MINSTRET)),
        .i_wr_hi (w_we && (csr.csr_addr == CSR_MINSTRETH)),
        .i_wdata (w_new),
        .o_count (w_minstret)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_mtip     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
        end else begin
            r_mtip <= timer_irq;
            if (trap_valid) begin
                r_mepc   <= {trap_pc[31:2], 2'b00};
                r_mcause <= trap_cause;
                r_mtval  <= trap_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (mret_valid) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_we) begin
                case (csr.csr_addr)
                    CSR_MSTATUS: begin
                        r_mie  <= w_new[MSTATUS_MIE];
                        r_mpie <= w_new[MSTATUS_MPIE];
                    end
                    CSR_MIE:      r_mtie     <= w_new[MIE_MTIE];
                    CSR_MTVEC:    r_mtvec    <= mtvec_legalize(w_new);
                    CSR_MSCRATCH: r_mscratch <= w_new;
                    CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
                    CSR_MCAUSE:   r_mcause   <= w_new;
                    CSR_MTVAL:    r_mtval    <= w_new;
                    default: ;
                endcase
            end
        end
    end

    // Vectored mode offsets only interrupts, by 4 * cause code.
    always_comb begin
        redirect_pc = 32'd0;
        if (trap_valid) begin
            redirect_pc = {r_mtvec[31:2], 2'b00};
            if ((r_mtvec[1:0] == 2'b01) && trap_cause[31])
                redirect_pc = redirect_pc + {25'd0, trap_cause[4:0], 2'b00};
        end else if (mret_valid) begin
            redirect_pc = r_mepc;
        end
    end

    assign redirect_valid = !rst && (trap_valid || mret_valid);
    assign irq_pending    = !rst && r_mie && r_mtie && r_mtip;
    assign mtvec          = r_mtvec;
    assign mepc           = r_mepc;
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: drivers push expected CSR and redirect responses
// into queues, negedge monitors pop and compare whenever the DUT responds.
module tb_csr_unit;
  import csr_pkg::*;

  localparam int          HART    = 3;
  localparam logic [31:0] MTV_RST = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst;
  logic        instret, timer_irq, trap_valid, mret_valid;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        redirect_valid, irq_pending;
  logic [31:0] redirect_pc, mtvec, mepc;

  csr_if bus ();

  csr_unit #(.HARTID(HART), .MTVEC_RESET(MTV_RST)) dut (
    .clk(clk), .rst(rst), .csr(bus), .instret(instret), .timer_irq(timer_irq),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_valid(mret_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irq_pending(irq_pending), .mtvec(mtvec), .mepc(mepc)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [33:0] exp_q[$];   // {check_rdata, illegal, rdata}
  logic [31:0] redir_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && bus.csr_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_access: addr %h with no expected entry", bus.csr_addr);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("illegal@%h", bus.csr_addr), {31'd0, bus.csr_illegal}, {31'd0, e[32]});
        if (e[33]) check($sformatf("rdata@%h", bus.csr_addr), bus.csr_rdata, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && redirect_valid) begin
      if (redir_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_redirect: pc %h", redirect_pc);
      end else begin
        check("redirect_pc", redirect_pc, redir_q.pop_front());
      end
    end
  end

  // drivers
  task automatic defaults();
    bus.csr_valid = 1'b0; bus.csr_op = CSR_OP_NONE; bus.csr_addr = 12'h000;
    bus.csr_src_zero = 1'b0; bus.csr_wdata = 32'd0;
    trap_valid = 1'b0; mret_valid = 1'b0; instret = 1'b0;
    trap_cause = 32'd0; trap_pc = 32'd0; trap_tval = 32'd0;
  endtask

  task automatic put_csr(input logic [1:0] op, input logic [11:0] addr, input logic srcz,
                         input logic [31:0] wdata, input logic chk, input logic ill,
                         input logic [31:0] exp);
    bus.csr_valid = 1'b1; bus.csr_op = op; bus.csr_addr = addr;
    bus.csr_src_zero = srcz; bus.csr_wdata = wdata;
    exp_q.push_back({chk, ill, exp});
  endtask

  task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic srcz,
                        input logic [31:0] wdata, input logic chk, input logic ill,
                        input logic [31:0] exp);
    @(posedge clk); #1;
    defaults();
    put_csr(op, addr, srcz, wdata, chk, ill, exp);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp);
    access(CSR_OP_RS, addr, 1'b1, 32'd0, 1'b1, 1'b0, exp);
  endtask

  task automatic idle(input int n, input logic ins);
    repeat (n) begin
      @(posedge clk); #1;
      defaults();
      instret = ins;
    end
  endtask

  task automatic put_trap(input logic [31:0] cause, input logic [31:0] pc,
                          input logic [31:0] tval, input logic [31:0] exp_pc);
    trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
    redir_q.push_back(exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; timer_irq = 1'b0;
    defaults();
    trap_valid = 1'b1; mret_valid = 1'b1;   // reset must override both events
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("redirect_in_reset", {31'd0, redirect_valid}, 32'd0);
    check("irq_in_reset", {31'd0, irq_pending}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    defaults();
    @(negedge clk);
    check("mtvec_port_reset", mtvec, MTV_RST);
    check("mepc_port_reset", mepc, 32'd0);
    check("rdata_idle", bus.csr_rdata, 32'd0);

    rd(CSR_MTVEC, MTV_RST);
    rd(CSR_MSTATUS, 32'h0000_1800);
    rd(CSR_MHARTID, 32'(HART));

    // read-modify-write on mscratch
    access(CSR_OP_RW, CSR_MSCRATCH, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    access(CSR_OP_RS, CSR_MSCRATCH, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF);
    rd(CSR_MSCRATCH, 32'hDEAD_BEFF);
    access(CSR_OP_RC, CSR_MSCRATCH, 1'b0, 32'h0000_00FF, 1'b1, 1'b0, 32'hDEAD_BEFF);
    rd(CSR_MSCRATCH, 32'hDEAD_BE00);
    access(CSR_OP_NONE, CSR_MSCRATCH, 1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'hDEAD_BE00);
    rd(CSR_MSCRATCH, 32'hDEAD_BE00);

    // illegal accesses and read-only fields
    access(CSR_OP_RW, CSR_MHARTID, 1'b0, 32'h1234, 1'b1, 1'b1, 32'(HART));
    access(CSR_OP_RS, CSR_MHARTID, 1'b1, 32'h0, 1'b1, 1'b0, 32'(HART));
    access(CSR_OP_RW, 12'h7C0, 1'b0, 32'h5, 1'b1, 1'b1, 32'd0);
    access(CSR_OP_RW, CSR_MISA, 1'b0, 32'd0, 1'b1, 1'b0, 32'h4000_0100);
    rd(CSR_MISA, 32'h4000_0100);
    access(CSR_OP_RW, CSR_MTVEC, 1'b0, 32'h0000_1002, 1'b1, 1'b0, MTV_RST);
    rd(CSR_MTVEC, 32'h0000_1000);

    // counter wrap and write-over-increment
    access(CSR_OP_RW, CSR_MCYCLE, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0);
    access(CSR_OP_RW, CSR_MCYCLEH, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    idle(3, 1'b0);
    rd(CSR_MCYCLE, 32'd1);
    rd(CSR_MCYCLEH, 32'd0);
    access(CSR_OP_RW, CSR_MCYCLE, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    rd(CSR_MCYCLE, 32'h0000_0100);
    idle(3, 1'b1);
    rd(CSR_MINSTRET, 32'd3);
    rd(CSR_MINSTRETH, 32'd0);

    // timer interrupt, vectored trap entry and mret
    access(CSR_OP_RW, CSR_MSTATUS, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_1800);
    timer_irq = 1'b1;
    access(CSR_OP_RW, CSR_MIE, 1'b0, 32'h0000_0080, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    check("irq_before_mie", {31'd0, irq_pending}, 32'd0);
    rd(CSR_MIP, 32'h0000_0080);
    @(negedge clk);
    check("irq_pending_on", {31'd0, irq_pending}, 32'd1);
    access(CSR_OP_RW, CSR_MTVEC, 1'b0, 32'h0000_0201, 1'b1, 1'b0, 32'h0000_1000);
    @(posedge clk); #1;
    defaults();
    put_trap(CAUSE_MTI, 32'h0000_0102, 32'h0000_0055, 32'h0000_021C);
    rd(CSR_MEPC, 32'h0000_0100);
    rd(CSR_MSTATUS, 32'h0000_1880);
    @(negedge clk);
    check("irq_after_trap", {31'd0, irq_pending}, 32'd0);
    check("mepc_port", mepc, 32'h0000_0100);
    rd(CSR_MCAUSE, CAUSE_MTI);
    rd(CSR_MTVAL, 32'h0000_0055);
    @(posedge clk); #1;
    defaults();
    mret_valid = 1'b1;
    redir_q.push_back(32'h0000_0100);
    rd(CSR_MSTATUS, 32'h0000_1888);

    // trap, mret and a CSR write together: only the trap lands
    @(posedge clk); #1;
    defaults();
    put_trap(CAUSE_ECALL, 32'h0000_0200, 32'h0000_ABCD, 32'h0000_0200);
    mret_valid = 1'b1;
    put_csr(CSR_OP_RW, CSR_MSCRATCH, 1'b0, 32'h0000_5555, 1'b1, 1'b0, 32'hDEAD_BE00);
    rd(CSR_MSCRATCH, 32'hDEAD_BE00);
    rd(CSR_MCAUSE, CAUSE_ECALL);
    rd(CSR_MTVAL, 32'h0000_ABCD);
    rd(CSR_MSTATUS, 32'h0000_1880);

    idle(2, 1'b0);
    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("redir_q_drained", 32'(redir_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
